// File: rtl/mem_if_rr_arbiter_if.sv
// mem_if bundle shared by the requesters and the downstream port of
// mem_if_rr_arbiter. N_PORTS is the number of requesters carried by one
// instance: NUM_PORTS on the requester side, 1 on the shared side.
// Address, write data and byte enables are flattened, with port i at slice i.
// Response data and error are a single copy, broadcast to every port.
interface mem_if_rr_arbiter_if #(
   parameter int N_PORTS    = 1,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [N_PORTS-1:0]              req;
   logic [N_PORTS*ADDR_WIDTH-1:0]   addr;
   logic [N_PORTS-1:0]              we;
   logic [N_PORTS*DATA_WIDTH-1:0]   wdata;
   logic [N_PORTS*DATA_WIDTH/8-1:0] be;
   logic [N_PORTS-1:0]              gnt;
   logic [N_PORTS-1:0]              rsp_valid;
   logic [DATA_WIDTH-1:0]           rsp_rdata;
   logic                            rsp_error;

   // Side that issues requests and consumes responses.
   modport master (
      output req, addr, we, wdata, be,
      input  gnt, rsp_valid, rsp_rdata, rsp_error
   );

   // Side that accepts requests and produces responses.
   modport slave (
      input  req, addr, we, wdata, be,
      output gnt, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/mem_if_rr_arbiter.sv
// mem_if_rr_arbiter: shares one mem_if master port between NUM_PORTS
// requesters.
//
// A request is forwarded combinationally. If the shared port stalls it, the
// arbiter latches the selection and holds the request stable until it is
// granted. Every handshake pushes the winning port index into a route FIFO.
// In-order responses pop the FIFO and are strobed back to the port at its
// head. A response that arrives while the FIFO is empty is dropped and sets
// the sticky rsp_orphan flag.
//
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN
//   defined   - port 0 wins every fresh arbitration. Ports 1..NUM_PORTS-1
//               round-robin among themselves, and rr_ptr moves only on their
//               grants. A held request is never preempted.
//   undefined - pure round-robin across all ports.
module mem_if_rr_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   mem_if_rr_arbiter_if.slave        s_mem,
   mem_if_rr_arbiter_if.master       m_mem,
   output logic                      rsp_orphan
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int FIFO_AW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W    = FIFO_AW + 1;

   localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PORT  = PTR_W'(NUM_PORTS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [PTR_W-1:0]     sel_r;
   logic [PTR_W-1:0]     sel_s;
   logic [PTR_W-1:0]     cand_s;
   logic                 found_s;
   logic [PTR_W-1:0]     rr_ptr_r;
   logic [PTR_W-1:0]     rr_ptr_nxt_s;
   logic                 fsm_req_s;
   logic                 req_out_s;
   logic                 handshake_s;

   logic [PTR_W-1:0]     route_mem_r [MAX_OUTSTANDING];
   logic [FIFO_AW-1:0]   wr_ptr_r;
   logic [FIFO_AW-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]     count_r;
   logic                 full_s;
   logic                 empty_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 orphan_s;
   logic [PTR_W-1:0]     head_s;
   logic                 rsp_orphan_r;

   logic [NUM_PORTS-1:0] gnt_s;
   logic [NUM_PORTS-1:0] rsp_valid_s;

   // Port index reached by stepping 'offset' places from 'start'. Indices at
   // or beyond NUM_PORTS fold back by 'span'. This covers both the full ring
   // (span NUM_PORTS) and the ring of ports 1..NUM_PORTS-1 (span NUM_PORTS-1).
   function automatic logic [PTR_W-1:0] rotate_idx(input int start,
                                                    input int offset,
                                                    input int span);
      int idx;
      idx = start + offset;
      if (idx >= NUM_PORTS) begin
         idx = idx - span;
      end else begin
         idx = idx;
      end
      return PTR_W'(idx);
   endfunction

   assign full_s   = (count_r == FIFO_DEPTH);
   assign empty_s  = (count_r == {CNT_W{1'b0}});
   assign head_s   = route_mem_r[rd_ptr_r];

`ifdef MEM_ARB_FIXED_PRIO_EN
   // Fresh winner: port 0 first, then the first of ports 1..N-1 at or after rr_ptr.
   always_comb begin
      cand_s  = {PTR_W{1'b0}};
      found_s = 1'b0;
      if (s_mem.req[0]) begin
         cand_s  = {PTR_W{1'b0}};
         found_s = 1'b1;
      end else begin
         for (int k = 0; k < NUM_PORTS - 1; k++) begin
            if (!found_s &&
                s_mem.req[rotate_idx((rr_ptr_r == {PTR_W{1'b0}}) ? 1 : int'(rr_ptr_r),
                                     k, NUM_PORTS - 1)]) begin
               found_s = 1'b1;
               cand_s  = rotate_idx((rr_ptr_r == {PTR_W{1'b0}}) ? 1 : int'(rr_ptr_r),
                                    k, NUM_PORTS - 1);
            end else begin
               found_s = found_s;
            end
         end
      end
   end
`else
   // Fresh winner: the first requesting port at or after rr_ptr, cyclically.
   always_comb begin
      cand_s  = {PTR_W{1'b0}};
      found_s = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!found_s && s_mem.req[rotate_idx(int'(rr_ptr_r), k, NUM_PORTS)]) begin
            found_s = 1'b1;
            cand_s  = rotate_idx(int'(rr_ptr_r), k, NUM_PORTS);
         end else begin
            found_s = found_s;
         end
      end
   end
`endif

   // FSM next state, active selection and forwarded request.
   always_comb begin
      state_nxt_s = state_r;
      sel_s       = cand_s;
      fsm_req_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            sel_s     = cand_s;
            fsm_req_s = found_s & ~full_s;
            if (fsm_req_s & ~m_mem.gnt) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            sel_s     = sel_r;
            fsm_req_s = 1'b1;
            if (m_mem.gnt) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            sel_s       = cand_s;
            fsm_req_s   = 1'b0;
         end
      endcase
   end

   // Forward nothing while reset is asserted, whatever the inputs do.
   assign req_out_s   = fsm_req_s & aresetn;
   assign handshake_s = req_out_s & m_mem.gnt;
   assign push_s      = handshake_s;
   assign pop_s       = m_mem.rsp_valid[0] & ~empty_s & aresetn;
   assign orphan_s    = m_mem.rsp_valid[0] & empty_s;

   // Next round-robin pointer: the port after the latest winner.
   always_comb begin
      rr_ptr_nxt_s = rr_ptr_r;
      if (handshake_s) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         if (sel_s != {PTR_W{1'b0}}) begin
            rr_ptr_nxt_s = (sel_s == LAST_PORT) ? {PTR_W{1'b0}} : sel_s + PTR_W'(1);
         end else begin
            rr_ptr_nxt_s = rr_ptr_r;
         end
`else
         rr_ptr_nxt_s = (sel_s == LAST_PORT) ? {PTR_W{1'b0}} : sel_s + PTR_W'(1);
`endif
      end else begin
         rr_ptr_nxt_s = rr_ptr_r;
      end
   end

   // One-hot grant to the selected port and response strobe to the FIFO head.
   always_comb begin
      gnt_s       = {NUM_PORTS{1'b0}};
      rsp_valid_s = {NUM_PORTS{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         gnt_s[i]       = handshake_s & (int'(sel_s) == i);
         rsp_valid_s[i] = pop_s & (int'(head_s) == i);
      end
   end

   assign m_mem.req[0] = req_out_s;
   assign m_mem.addr   = s_mem.addr[int'(sel_s)*ADDR_WIDTH +: ADDR_WIDTH];
   assign m_mem.we[0]  = s_mem.we[sel_s];
   assign m_mem.wdata  = s_mem.wdata[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
   assign m_mem.be     = s_mem.be[int'(sel_s)*BE_WIDTH +: BE_WIDTH];

   assign s_mem.gnt       = gnt_s;
   assign s_mem.rsp_valid = rsp_valid_s;
   assign s_mem.rsp_rdata = m_mem.rsp_rdata;
   assign s_mem.rsp_error = m_mem.rsp_error;
   assign rsp_orphan      = rsp_orphan_r;

   // State, held selection, pointer, FIFO bookkeeping and sticky orphan flag.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r      <= ST_IDLE;
         sel_r        <= {PTR_W{1'b0}};
         rr_ptr_r     <= {PTR_W{1'b0}};
         wr_ptr_r     <= {FIFO_AW{1'b0}};
         rd_ptr_r     <= {FIFO_AW{1'b0}};
         count_r      <= {CNT_W{1'b0}};
         rsp_orphan_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         sel_r    <= sel_s;
         rr_ptr_r <= rr_ptr_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (orphan_s) begin
            rsp_orphan_r <= 1'b1;
         end else begin
            rsp_orphan_r <= rsp_orphan_r;
         end
      end
   end

   // Route FIFO storage; entries are only read while count_r says they are live.
   always_ff @(posedge aclk) begin
      if (push_s) begin
         route_mem_r[wr_ptr_r] <= sel_s;
      end else begin
         route_mem_r[wr_ptr_r] <= route_mem_r[wr_ptr_r];
      end
   end
endmodule

// File: tb/tb_mem_if_rr_arbiter.sv
// Self-checking bench for mem_if_rr_arbiter (3 ports, FIFO depth 4).
// The reference model tracks the last winner, a held-request flag and a
// queue of granted ports, and predicts the behaviour cycle by cycle.
// Fixed-priority expectations follow MEM_ARB_FIXED_PRIO_EN when it is defined.
`timescale 1ns/1ps
module tb_mem_if_rr_arbiter;
   localparam int NP = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MO = 4;
   localparam int BW = DW / 8;

   logic aclk;
   logic aresetn;
   logic rsp_orphan;
   int   checks;
   int   errors;
   int   cyc;

   mem_if_rr_arbiter_if #(.N_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s_bus ();
   mem_if_rr_arbiter_if #(.N_PORTS(1),  .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_bus ();

   mem_if_rr_arbiter #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .s_mem(s_bus), .m_mem(m_bus), .rsp_orphan(rsp_orphan)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Requester-side stimulus.
   logic [AW-1:0] p_addr  [NP];
   logic          p_we    [NP];
   logic [DW-1:0] p_wdata [NP];
   logic [BW-1:0] p_be    [NP];
   logic          pend    [NP];

   // Reference model state.
   int      last_rr;
   int      last_other;
   bit      held;
   int      held_port;
   int      route_q[$];
   logic    m_orphan;
   logic    exp_mreq;
   int      exp_sel;
   logic [NP-1:0] exp_gnt;
   logic [NP-1:0] exp_rspv;
   logic    exp_pop;
   logic    cur_gnt;
   logic    cur_rv;

   task automatic model_reset();
      last_rr    = NP - 1;
      last_other = NP - 1;
      held       = 1'b0;
      held_port  = 0;
      route_q.delete();
      m_orphan   = 1'b0;
   endtask

   function automatic int pick();
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (pend[0]) return 0;
      for (int k = 1; k < NP; k++) begin
         int p;
         p = 1 + ((last_other - 1 + k) % (NP - 1));
         if (pend[p]) return p;
      end
      return -1;
`else
      for (int k = 1; k <= NP; k++) begin
         int p;
         p = (last_rr + k) % NP;
         if (pend[p]) return p;
      end
      return -1;
`endif
   endfunction

   task automatic model_eval(input logic g, input logic rv);
      cur_gnt  = g;
      cur_rv   = rv;
      exp_sel  = held ? held_port : pick();
      exp_mreq = held || (exp_sel >= 0 && route_q.size() < MO);
      exp_gnt  = '0;
      if (exp_mreq && g) exp_gnt[exp_sel] = 1'b1;
      exp_rspv = '0;
      exp_pop  = rv && (route_q.size() > 0);
      if (exp_pop) exp_rspv[route_q[0]] = 1'b1;
   endtask

   task automatic model_commit();
      if (exp_pop) void'(route_q.pop_front());
      else if (cur_rv) m_orphan = 1'b1;
      if (exp_mreq && cur_gnt) begin
         route_q.push_back(exp_sel);
         held = 1'b0;
         last_rr = exp_sel;
         if (exp_sel != 0) last_other = exp_sel;
      end else if (exp_mreq) begin
         held      = 1'b1;
         held_port = exp_sel;
      end
   endtask

   task automatic new_txn(input int i);
      p_addr[i]  = $urandom;
      p_we[i]    = 1'($urandom);
      p_wdata[i] = $urandom;
      p_be[i]    = BW'($urandom);
   endtask

   task automatic apply(input logic g, input logic rv, input logic [DW-1:0] rd, input logic re);
      for (int i = 0; i < NP; i++) begin
         s_bus.req[i]               = pend[i];
         s_bus.addr[i*AW +: AW]     = p_addr[i];
         s_bus.we[i]                = p_we[i];
         s_bus.wdata[i*DW +: DW]    = p_wdata[i];
         s_bus.be[i*BW +: BW]       = p_be[i];
      end
      m_bus.gnt       = g;
      m_bus.rsp_valid = rv;
      m_bus.rsp_rdata = rd;
      m_bus.rsp_error = re;
   endtask

   // Drive one cycle's inputs at the falling edge and predict the outputs.
   task automatic step(input logic g, input logic rv, input logic [DW-1:0] rd, input logic re);
      @(negedge aclk);
      apply(g, rv, rd, re);
      #1;
      model_eval(g, rv);
   endtask

   task automatic tick();
      @(posedge aclk);
      model_commit();
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      for (int i = 0; i < NP; i++) begin
         pend[i] = 1'b0;
         new_txn(i);
      end
      apply(1'b0, 1'b0, '0, 1'b0);
      @(posedge aclk);
      @(posedge aclk);
      model_reset();
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      for (int i = 0; i < NP; i++) pend[i] = 1'b1;
      apply(1'b1, 1'b1, 32'h1234_5678, 1'b1);
      #1;
      checks++;
      if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: req/gnt/rsp_valid got %b want 0", {m_bus.req, s_bus.gnt, s_bus.rsp_valid});
      end
      @(posedge aclk);
      #1;
      checks++;
      if (rsp_orphan !== 1'b0) begin
         errors++;
         $display("FAIL reset_orphan: got %b want 0", rsp_orphan);
      end
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [NP-1:0] want;
      do_reset();
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         step(1'b1, t >= 2, 32'(t), 1'b0);
         want = (t % 2 == 0) ? 3'b001 : 3'b010;
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL rr_model cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         checks++;
         if (s_bus.gnt !== want || s_bus.rsp_valid !== ((t >= 2) ? want : 3'b000)) begin
            errors++;
            $display("FAIL rr_alternate t=%0d: gnt %b rsp %b want gnt %b", t, s_bus.gnt, s_bus.rsp_valid, want);
         end
         tick();
      end
   endtask

   task automatic test_hold();
      logic [NP-1:0] want_g;
      do_reset();
      pend[1]   = 1'b1;
      p_addr[1] = 32'h0027_1bd0;
      p_we[1]   = 1'b0;
      p_addr[0] = 32'h0000_a5a0;
      for (int t = 0; t < 5; t++) begin
         if (t == 1) pend[0] = 1'b1;
         step(t >= 3, 1'b0, '0, 1'b0);
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL hold_model cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         want_g = (t < 3) ? 3'b000 : ((t == 3) ? 3'b010 : 3'b001);
         checks++;
         if (m_bus.addr !== ((t < 4) ? 32'h0027_1bd0 : 32'h0000_a5a0) || s_bus.gnt !== want_g || m_bus.req !== 1'b1) begin
            errors++;
            $display("FAIL hold_addr t=%0d: addr %h gnt %b req %b want gnt %b", t, m_bus.addr, s_bus.gnt, m_bus.req, want_g);
         end
         tick();
         if (t == 3) pend[1] = 1'b0;
      end
   endtask

   task automatic test_full_drain();
      do_reset();
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      for (int t = 0; t < 7; t++) begin
         step(1'b1, t == 5, 32'hd72b_2ed6, 1'b0);
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL full_model cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         if (t == 4 || t == 5) begin
            checks++;
            if (m_bus.req !== 1'b0) begin
               errors++;
               $display("FAIL full_block t=%0d: m_mem_req %b want 0", t, m_bus.req);
            end
         end
         if (t == 5) begin
            checks++;
            if (s_bus.rsp_valid !== 3'b001 || s_bus.rsp_rdata !== 32'hd72b_2ed6) begin
               errors++;
               $display("FAIL drain_route: rsp_valid %b rdata %h want 001 d72b2ed6", s_bus.rsp_valid, s_bus.rsp_rdata);
            end
         end
         if (t == 6) begin
            checks++;
            if (m_bus.req !== 1'b1 || s_bus.gnt !== 3'b001) begin
               errors++;
               $display("FAIL drain_reassert: req %b gnt %b want 1 001", m_bus.req, s_bus.gnt);
            end
         end
         tick();
      end
   endtask

   task automatic test_push_pop();
      logic [NP-1:0] order [4];
      order[0] = 3'b010; order[1] = 3'b001; order[2] = 3'b010; order[3] = 3'b001;
      do_reset();
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      for (int t = 0; t < 11; t++) begin
         if (t == 6) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
         end
         step(t <= 5, (t == 3) || (t >= 6 && t <= 9), 32'(t), 1'b0);
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL pushpop_model cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         if (t == 5) begin
            checks++;
            if (m_bus.req !== 1'b0) begin
               errors++;
               $display("FAIL pushpop_count: m_mem_req %b want 0 after refill", m_bus.req);
            end
         end
         if (t >= 6 && t <= 9) begin
            checks++;
            if (s_bus.rsp_valid !== order[t-6]) begin
               errors++;
               $display("FAIL pushpop_order t=%0d: rsp_valid %b want %b", t, s_bus.rsp_valid, order[t-6]);
            end
         end
         tick();
      end
   endtask

   task automatic test_orphan();
      do_reset();
      for (int t = 0; t < 4; t++) begin
         step(1'b0, t == 0, 32'hdead_beef, 1'b1);
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL orphan_model cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         checks++;
         if (s_bus.rsp_valid !== 3'b000 || rsp_orphan !== (t > 0)) begin
            errors++;
            $display("FAIL orphan_flag t=%0d: rsp_valid %b orphan %b", t, s_bus.rsp_valid, rsp_orphan);
         end
         tick();
      end
      @(negedge aclk);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      checks++;
      if (rsp_orphan !== 1'b0) begin
         errors++;
         $display("FAIL orphan_clear: got %b want 0", rsp_orphan);
      end
      do_reset();
   endtask

   task automatic test_three_ports();
      logic [NP-1:0] seq [10];
`ifdef MEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 6; i++) seq[i] = 3'b001;
`else
      for (int i = 0; i < 6; i++) seq[i] = 3'b001 << (i % 3);
`endif
      seq[6] = 3'b010; seq[7] = 3'b100; seq[8] = 3'b010; seq[9] = 3'b100;
      do_reset();
      for (int i = 0; i < NP; i++) pend[i] = 1'b1;
      for (int t = 0; t < 10; t++) begin
         if (t == 6) pend[0] = 1'b0;
         step(1'b1, t >= 2, 32'(t), 1'b0);
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL three_model cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         checks++;
         if (s_bus.gnt !== seq[t]) begin
            errors++;
            $display("FAIL three_seq t=%0d: gnt %b want %b", t, s_bus.gnt, seq[t]);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic          g;
      logic          rv;
      logic [DW-1:0] rd;
      logic          re;
      do_reset();
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < NP; i++) begin
            if (!pend[i] && ($urandom % 3 == 0)) begin
               pend[i] = 1'b1;
               new_txn(i);
            end
         end
         g  = ($urandom % 4) != 0;
         rv = (route_q.size() > 0) ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
         rd = $urandom;
         re = 1'($urandom);
         step(g, rv, rd, re);
         checks++;
         if ({m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan} !== {exp_mreq, exp_gnt, exp_rspv, m_orphan}) begin
            errors++;
            $display("FAIL rand_ctrl cycle %0d: got %b want %b", cyc,
                     {m_bus.req, s_bus.gnt, s_bus.rsp_valid, rsp_orphan}, {exp_mreq, exp_gnt, exp_rspv, m_orphan});
         end
         if (exp_mreq) begin
            checks++;
            if ({m_bus.addr, m_bus.we, m_bus.wdata, m_bus.be} !==
                {p_addr[exp_sel], p_we[exp_sel], p_wdata[exp_sel], p_be[exp_sel]}) begin
               errors++;
               $display("FAIL rand_mux cycle %0d: addr %h we %b wdata %h be %h want port %0d addr %h",
                        cyc, m_bus.addr, m_bus.we, m_bus.wdata, m_bus.be, exp_sel, p_addr[exp_sel]);
            end
         end
         checks++;
         if (s_bus.rsp_rdata !== rd || s_bus.rsp_error !== re) begin
            errors++;
            $display("FAIL rand_rsp_pass cycle %0d: rdata %h err %b want %h %b", cyc, s_bus.rsp_rdata, s_bus.rsp_error, rd, re);
         end
         tick();
         for (int i = 0; i < NP; i++) begin
            if (exp_gnt[i]) pend[i] = 1'b0;
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      aresetn = 1'b0;
      for (int i = 0; i < NP; i++) begin
         pend[i] = 1'b0;
         new_txn(i);
      end
      model_reset();
      test_reset();
      test_round_robin();
      test_hold();
      test_full_drain();
      test_push_pop();
      test_orphan();
      test_three_ports();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_if_rr_arbiter.md
# mem_if_rr_arbiter

- Round-robin arbiter that shares one `mem_if` master port between `NUM_PORTS` requesters, e.g. mcore util/bitstream reader and DMA clients.
- Downstream of the arbiter is the `xaxi_from_mem_wrapper` bridge.
- Holds the forwarded request stable until it is granted.
- Records the grant order in a route FIFO, so in-order responses return to the port that issued them.

## Interface

- `NUM_PORTS`, 2, number of requesters (2..8)
- `DATA_WIDTH`, 32, mem_if data width
- `ADDR_WIDTH`, 32, mem_if address width
- `MAX_OUTSTANDING`, 4, route FIFO depth; power of two, 2..16

- `aclk`  in  1  clock
- `aresetn`  in  1  synchronous, active-low reset
- `s_mem_req`  in  NUM_PORTS  per-port request
- `s_mem_addr`  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i
- `s_mem_we`  in  NUM_PORTS  per-port write enable
- `s_mem_wdata`  in  NUM_PORTS*DATA_WIDTH  per-port write data
- `s_mem_be`  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables
- `s_mem_gnt`  out  NUM_PORTS  per-port grant
- `s_mem_rsp_valid`  out  NUM_PORTS  per-port response strobe
- `s_mem_rsp_rdata`  out  DATA_WIDTH  response data, broadcast to all ports
- `s_mem_rsp_error`  out  1  response error, broadcast to all ports
- `m_mem_req`, `m_mem_addr`, `m_mem_we`, `m_mem_wdata`, `m_mem_be`  out  request to the shared port
- `m_mem_gnt`, `m_mem_rsp_valid`, `m_mem_rsp_rdata`, `m_mem_rsp_error`  in  from the shared port
- `rsp_orphan`  out  1  sticky flag: a response arrived while the route FIFO was empty

## Operation

**Protocol**
- A transfer is accepted when `req & gnt` are both high.
- Every accepted request, read or write, produces exactly one `rsp_valid`. Responses come back in order.

**States**
- IDLE
  - Select the first requesting port at or after `rr_ptr`, cyclically.
  - Drive `m_mem_req` only if some port requests and the FIFO is not full.
  - Mux the selected port's addr/we/wdata/be onto `m_mem_*`.
  - If `m_mem_req & ~m_mem_gnt`: register `sel`, go to HOLD.
  - On a handshake: stay in IDLE.
- HOLD
  - Selection frozen at the registered `sel`.
  - `m_mem_req` stays high and `m_mem_*` stays stable regardless of other ports' requests.
  - On `m_mem_gnt`: go to IDLE.

**Grant and pointer**
- `s_mem_gnt[i] = m_mem_gnt & m_mem_req & (sel == i)`. Purely combinational; no other port sees a grant.
- On a handshake: push `sel` into the route FIFO and set `rr_ptr <= sel+1`, wrapping from `NUM_PORTS-1` to 0.

**Response routing**
- On `m_mem_rsp_valid` with the FIFO non-empty: `s_mem_rsp_valid[head] = 1`, then pop.
- rdata and error pass through combinationally.

**Boundary conditions**
- **Full:** no new `m_mem_req` in IDLE. HOLD is only entered when not full, so full never blocks a request already in HOLD.
- **Push and pop in the same cycle:** count unchanged. When full, the pop frees the slot that the same-cycle push uses only if the handshake was already permitted; the full check uses the registered count.
- **Empty with `rsp_valid`:** response dropped, no `s_mem_rsp_valid`, `rsp_orphan <= 1` until reset.
- **A requester drops `req` while in HOLD:** protocol violation. The arbiter still holds the latched request.
- **Reset mid-operation:** FIFO contents discarded. The downstream bridge must be reset together with the arbiter, otherwise late responses set `rsp_orphan`.

## Timing

- Request path from `s_mem_req` to `m_mem_req` is zero-latency combinational. Grant path from `m_mem_gnt` to `s_mem_gnt` is also combinational.
- Response path from `m_mem_rsp_valid` to `s_mem_rsp_valid` is zero-latency combinational. Only the FIFO head is registered.
- State, `rr_ptr`, FIFO and `rsp_orphan` all update on `posedge aclk`.
- Sustained throughput is 1 grant/cycle while `m_mem_gnt` is high and the FIFO is not full.
- Reset values:
  - state IDLE, `rr_ptr` 0, FIFO empty, `rsp_orphan` 0.
  - `m_mem_req`, `s_mem_gnt` and `s_mem_rsp_valid` are 0 while `aresetn` is low, independent of the inputs.

## Configuration

- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: in IDLE, port 0 wins whenever it requests. The remaining ports round-robin among themselves, with `rr_ptr` advancing only on their grants. HOLD still freezes the selection, so port 0 never preempts a held request.
  - Undefined: pure round-robin across all ports.

## Test plan

- **Continuous round-robin:** ports 0 and 1 request continuously, `m_mem_gnt=1`, responses returned 2 cycles later → grants alternate 0,1,0,1, and each `s_mem_rsp_valid` pulses on the port that issued the request.
- **HOLD stability:** port 1 reads 0x271bd0 with `m_mem_gnt=0` for 3 cycles; port 0 raises `req` in cycle 2 → `m_mem_addr` stays 0x271bd0 until the grant, then port 0 is granted the next cycle.
- **Full and drain:** `MAX_OUTSTANDING=4`, no responses → `m_mem_req=0` after 4 grants. One `rsp_valid` with data 0xd72b2ed6 → routed to the first grantee, and `m_mem_req` reasserts the following cycle.
- **Same-cycle push/pop:** at count 3, a handshake and a response in the same cycle → count stays 3 and routing order is preserved.
- **Orphan response:** `m_mem_rsp_valid` with the FIFO empty → no `s_mem_rsp_valid`, `rsp_orphan=1` until `aresetn` goes low.
- **Fixed priority:** with `MEM_ARB_FIXED_PRIO_EN`, ports 0, 1 and 2 request continuously → grants 0,0,0…; when port 0 drops `req`, grants alternate 1,2.
